// File: rtl/rom_stream_reader.sv
// Purpose  : block-read sequencer in front of a synchronous ROM (1-cycle read latency);
//            streams len words from start_addr (wrapping at DEPTH) on valid/ready.
// Latency  : first out_valid 2 cycles after start is accepted, then 1 word/cycle.
// Backpres.: 2-entry output skid FIFO; reads are issued only when the returning word
//            is guaranteed a slot, so stalls never drop or duplicate words.
// Ports    : clk/rst (sync, active-high); start/start_addr/len request a block;
//            rom_addr -> ROM, rom_data <- ROM; out_data/out_valid/out_ready stream;
//            busy spans the transfer; done pulses one cycle after the last beat.
module rom_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   issue_rem;   // reads still to issue
  logic [ADDR_WIDTH:0]   beat_rem;    // beats still to be accepted downstream
  logic                  in_flight;   // a read was issued last cycle; rom_data holds it now

  logic [WIDTH-1:0]      fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  pop;
  logic                  push;
  logic [1:0]            occ_after;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = in_flight;

  // FIFO occupancy once this cycle's capture and pop have happened. A read issued
  // now is captured at the end of next cycle, when next cycle may not pop at all,
  // so it needs this occupancy to leave one free slot. Counting this cycle's pop
  // is what allows a read every cycle while the consumer keeps up.
  assign occ_after = fifo_cnt + 2'(in_flight) - 2'(pop);
  assign issue     = (state == S_FETCH) && (occ_after < 2'd2);
  assign addr_next = (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_rem   <= '0;
      beat_rem    <= '0;
      in_flight   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;

      if (push) begin
        fifo_mem[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_rem <= beat_rem - 1'b1;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              // rom_addr is preloaded here; the first read is issued next cycle.
              rom_addr  <= start_addr;
              issue_rem <= len;
              beat_rem  <= len;
              busy      <= 1'b1;
              state     <= S_FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            rom_addr  <= addr_next;
            issue_rem <= issue_rem - 1'b1;
            if (issue_rem == 1) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && beat_rem == 1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1,0,1
  int pat_idx  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem [DEPTH];

  always #5 clk = ~clk;

  rom_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  // Registered-read ROM, MEM[i] = i + 8'h10
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 16);
  always @(posedge clk) rom_data <= mem[rom_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: word i of a block is ROM[(addr+i) mod DEPTH]
  function automatic logic [7:0] ref_word(input int a, input int i);
    return 8'(((a + i) % DEPTH) + 16);
  endfunction

  // Consumer-ready driver
  initial begin
    logic [5:0] pat;
    pat = 6'b101001;   // bit k = ready at step k: 1,0,0,1,0,1
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[pat_idx];
          pat_idx = (pat_idx == 5) ? 0 : pat_idx + 1;
        end
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("rom_addr_range", 32'(rom_addr < AW'(DEPTH)), 32'd1);
        if (prev_stall) begin
          chk("stall_valid_held", 32'(out_valid), 32'd1);
          chk("stall_data_held", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e));
          end
          beats++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // One block transfer; mid >= 0 pulses start at that cycle while busy.
  task automatic do_block(input int a, input int l, input int mode, input bit timing, input int mid);
    int n;
    int first_v;
    ready_mode = mode;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(a); len = (AW+1)'(l);
    for (int i = 0; i < l; i++) exp_q.push_back(ref_word(a, i));
    @(posedge clk); #1;
    start = 1'b0;
    if (l == 0) begin
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk("len0_no_valid", 32'(out_valid), 32'd0);
        chk("len0_done_once", 32'(done), 32'd0);
      end
      return;
    end
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    first_v = -1;
    while (n < 3000 && !done) begin
      if (out_valid && first_v < 0) first_v = n;
      start = (n == mid);
      start_addr = AW'((a + 9) % DEPTH);
      len = (AW+1)'(5);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (timing) begin
      chk("first_valid_latency", 32'(first_v), 32'd2);
      chk("cycles_to_done", 32'(n), 32'(l + 2));
    end
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("all_words_seen", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("idle_no_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    do_block(0, 4, 0, 1'b1, -1);      // basic, timing
    do_block(62, 4, 0, 1'b1, -1);     // wrap 63 -> 0
    pat_idx = 0;
    do_block(5, 6, 2, 1'b0, -1);      // stall pattern
    do_block(0, 0, 0, 1'b0, -1);      // zero length
    do_block(0, 64, 0, 1'b1, 20);     // full depth, stray start ignored

    // Reset mid-transfer after 3 beats
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(20); len = (AW+1)'(10);
    for (int i = 0; i < 10; i++) exp_q.push_back(ref_word(20, i));
    base = beats;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (beats < base + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("three_beats_seen", 32'(beats >= base + 3), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rom_addr", 32'(rom_addr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_block(0, 8, 0, 1'b1, -1);      // clean run after abort

    // Randomized blocks
    for (int t = 0; t < 12; t++) begin
      int ra;
      int rl;
      int rm;
      ra = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, DEPTH);
      rm = $urandom_range(0, 1);
      do_block(ra, rl, rm, (rm == 0), (t % 3 == 0) ? 3 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
